// File: rtl/green_mon_pkg.sv
// Shared helpers for the green sequence monitor: bit counting, one-hot decode
// and saturating increment. Vectors are zero-extended to MAX_CH bits by callers.
package green_mon_pkg;

    localparam int MAX_CH = 32;

    function automatic logic [5:0] popcount(input logic [MAX_CH-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < MAX_CH; i++) c = c + {5'd0, v[i]};
        return c;
    endfunction

    // Only meaningful for one-hot input; OR of indices keeps the decode shallow.
    function automatic logic [4:0] onehot_to_idx(input logic [MAX_CH-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) if (v[i]) idx = idx | 5'(i);
        return idx;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/green_sequence_monitor_starve_timer.sv
// Per-channel starvation timer: counts cycles without green, saturating at
// STARVE_LIMIT; starve_o is registered alongside the timer.
module starve_timer
    import green_mon_pkg::*;
#(
    parameter int STARVE_LIMIT = 200
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic green_i,
    output logic starve_o
);

    localparam int TW = $clog2(STARVE_LIMIT + 1);

    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;

    always_comb begin
        timer_next = '0;
        if (!green_i) timer_next = TW'(sat_inc(32'(timer), 32'(STARVE_LIMIT)));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer    <= '0;
            starve_o <= 1'b0;
        end else if (clear) begin
            timer    <= '0;
            starve_o <= 1'b0;
        end else begin
            timer    <= timer_next;
            starve_o <= (timer_next == TW'(STARVE_LIMIT));
        end
    end

endmodule

// File: rtl/green_sequence_monitor.sv
// Intersection green-signal monitor: records ordered sole-green hand-overs in a
// pair matrix, counts multi-green conflicts and flags starved channels (N <= 32).
module green_sequence_monitor
    import green_mon_pkg::*;
#(
    parameter  int NUM_CHANNELS = 4,
    parameter  int CNT_WIDTH    = 8,
    parameter  int STARVE_LIMIT = 200,
    localparam int IDX_W        = (NUM_CHANNELS > 2) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_CHANNELS-1:0]              green,
    input  logic                                 clear,
    output logic [NUM_CHANNELS*NUM_CHANNELS-1:0] pair_seen,
    output logic                                 all_pairs_seen,
    output logic                                 xfer_valid,
    output logic [IDX_W-1:0]                     xfer_from,
    output logic [IDX_W-1:0]                     xfer_to,
    output logic                                 conflict,
    output logic [CNT_WIDTH-1:0]                 conflict_count,
    output logic [NUM_CHANNELS-1:0]              starve
);

    localparam int NN = NUM_CHANNELS * NUM_CHANNELS;

    logic [MAX_CH-1:0] green_ext;
    logic [5:0]        pc;
    logic              sole, multi, handover;
    logic [IDX_W-1:0]  k;
    logic [IDX_W-1:0]  last_sole;
    logic              last_valid;
    logic [NN-1:0]     pair_next, diag_mask;

    assign green_ext = MAX_CH'(green);
    assign pc        = popcount(green_ext);
    assign sole      = (pc == 6'd1);
    assign multi     = (pc > 6'd1);
    assign k         = IDX_W'(onehot_to_idx(green_ext));
    assign handover  = sole && last_valid && (last_sole != k);

    // Diagonal is forced set in the AND so all_pairs_seen only needs off-diagonal hits.
    always_comb begin
        diag_mask = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) diag_mask[i*NUM_CHANNELS+i] = 1'b1;
        pair_next = pair_seen;
        if (handover) pair_next[int'(last_sole)*NUM_CHANNELS + int'(k)] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pair_seen      <= '0;
            all_pairs_seen <= 1'b0;
            xfer_valid     <= 1'b0;
            xfer_from      <= '0;
            xfer_to        <= '0;
            conflict       <= 1'b0;
            conflict_count <= '0;
            last_sole      <= '0;
            last_valid     <= 1'b0;
        end else if (clear) begin
            pair_seen      <= '0;
            all_pairs_seen <= 1'b0;
            xfer_valid     <= 1'b0;
            conflict       <= 1'b0;
            conflict_count <= '0;
            last_valid     <= 1'b0;
        end else begin
            pair_seen      <= pair_next;
            all_pairs_seen <= &(pair_next | diag_mask);
            xfer_valid     <= handover;
            conflict       <= multi;
            if (multi)
                conflict_count <= CNT_WIDTH'(sat_inc(32'(conflict_count), 32'({CNT_WIDTH{1'b1}})));
            if (sole) begin
                last_sole  <= k;
                last_valid <= 1'b1;
            end
            if (handover) begin
                xfer_from <= last_sole;
                xfer_to   <= k;
            end
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_starve
        starve_timer #(.STARVE_LIMIT(STARVE_LIMIT)) u_timer (
            .clock   (clock),
            .reset   (reset),
            .clear   (clear),
            .green_i (green[i]),
            .starve_o(starve[i])
        );
    end

endmodule
